fixed_dwn_lut_layer: RTL and testbench

- Downstream stage of the DWN thermometer encoder. It consumes the packed thermometer bit vector and evaluates NUM_LUTS fixed lookup tables.
- Each LUT selects LUT_N input bits through a compile-time wiring map and addresses a compile-time truth table. The result is one output bit per LUT.
- The result is registered behind a 2-entry skid buffer. This gives full-throughput valid/ready streaming with registered outputs and a registered ready.

---
 rtl/dwn_pkg.sv | 12 +
 rtl/dwn_skid_buffer.sv | 57 +++++
 rtl/fixed_dwn_lut_layer.sv | 56 +++++
 tb/tb_fixed_dwn_lut_layer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dwn_pkg.sv
// Shared helpers for the DWN LUT layer: sizing functions used at elaboration time.
package dwn_pkg;

    function automatic int lut_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lut_depth(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/dwn_skid_buffer.sv
// Main register plus one skid entry: full-throughput valid/ready with registered outputs and ready.
module dwn_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    logic [DATA_WIDTH-1:0] out_reg, skid_reg;
    logic                  out_valid, skid_valid;
    logic                  accept, consume, load_main, skid_load, skid_valid_n;

    assign data_out       = out_reg;
    assign data_out_valid = out_valid;

    always_comb begin
        accept    = data_in_valid & data_in_ready;
        consume   = out_valid & data_out_ready;
        load_main = ~out_valid | consume;
        // A stalled accept parks in the skid; a drained skid may also be refilled the same cycle.
        skid_load    = accept & (~load_main | skid_valid);
        skid_valid_n = skid_load | (skid_valid & ~load_main);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid     <= 1'b0;
            skid_reg      <= '0;
            skid_valid    <= 1'b0;
            data_in_ready <= 1'b0;
        end else begin
            if (load_main) begin
                if (skid_valid) begin
                    out_reg   <= skid_reg;
                    out_valid <= 1'b1;
                end else if (accept) begin
                    out_reg   <= data_in;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (skid_load)
                skid_reg <= data_in;
            skid_valid    <= skid_valid_n;
            data_in_ready <= ~skid_valid_n;
        end
    end

endmodule

// File: rtl/fixed_dwn_lut_layer.sv
// Fixed-wiring LUT layer: each LUT gathers LUT_N thermometer bits and looks up a constant truth table.
module fixed_dwn_lut_layer
    import dwn_pkg::*;
#(
    parameter int NUM_INPUTS = 32,
    parameter int NUM_LUTS   = 8,
    parameter int LUT_N      = 4,
    parameter logic [NUM_LUTS*LUT_N*lut_idx_w(NUM_INPUTS)-1:0] INPUT_INDICES = '0,
    parameter logic [NUM_LUTS*lut_depth(LUT_N)-1:0]            LUT_CONTENTS  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] data_in_0,
    input  logic                  data_in_0_valid,
    output logic                  data_in_0_ready,
    output logic [NUM_LUTS-1:0]   data_out_0,
    output logic                  data_out_0_valid,
    input  logic                  data_out_0_ready
);

    localparam int IDX_W = lut_idx_w(NUM_INPUTS);
    localparam int DEPTH = lut_depth(LUT_N);

    logic [NUM_LUTS-1:0][LUT_N-1:0] addr;
    logic [NUM_LUTS-1:0]            lut_res;

    // Sparse wiring maps leave some input bits unread; fold them here so that is not flagged.
    logic unused_inputs;
    assign unused_inputs = ^data_in_0;

    for (genvar l = 0; l < NUM_LUTS; l++) begin : g_lut
        localparam logic [DEPTH-1:0] TABLE = LUT_CONTENTS[l*DEPTH +: DEPTH];
        for (genvar k = 0; k < LUT_N; k++) begin : g_bit
            localparam logic [IDX_W-1:0] SEL = INPUT_INDICES[(l*LUT_N+k)*IDX_W +: IDX_W];
            if (int'(SEL) >= NUM_INPUTS) begin : g_bad_index
                $error("fixed_dwn_lut_layer: wiring index out of range");
            end
            assign addr[l][k] = data_in_0[SEL];
        end
        assign lut_res[l] = TABLE[addr[l]];
    end

    dwn_skid_buffer #(
        .DATA_WIDTH(NUM_LUTS)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .data_in       (lut_res),
        .data_in_valid (data_in_0_valid),
        .data_in_ready (data_in_0_ready),
        .data_out      (data_out_0),
        .data_out_valid(data_out_0_valid),
        .data_out_ready(data_out_0_ready)
    );

endmodule

// File: tb/tb_fixed_dwn_lut_layer.sv
// Scoreboard bench: LUT0 = AND(in0,in1), LUT1 = XOR(in7,in6), with directed and random backpressure.
module tb_fixed_dwn_lut_layer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [1:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [1:0] expq[$];
    bit         hold_v = 1'b0;
    logic [1:0] hold_d = '0;

    always #5 clk = ~clk;

    fixed_dwn_lut_layer #(
        .NUM_INPUTS   (8),
        .NUM_LUTS     (2),
        .LUT_N        (2),
        .INPUT_INDICES({3'd6, 3'd7, 3'd1, 3'd0}),
        .LUT_CONTENTS ({4'b0110, 4'b1000})
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (din),
        .data_in_0_valid (din_valid),
        .data_in_0_ready (din_ready),
        .data_out_0      (dout),
        .data_out_0_valid(dout_valid),
        .data_out_0_ready(dout_ready)
    );

    function automatic logic [1:0] model(input logic [7:0] x);
        return {x[7] ^ x[6], x[0] & x[1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: the expected result of every beat the DUT accepts.
    always @(negedge clk) begin
        if (!rst && din_valid && din_ready)
            expq.push_back(model(din));
    end

    // Monitor: compare each consumed beat against the scoreboard and watch stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("hold_stable", {30'd0, dout}, {30'd0, hold_d});
            if (dout_valid && dout_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat at %0t", dout, $time);
                end else begin
                    check("beat_data", {30'd0, dout}, {30'd0, expq.pop_front()});
                end
            end
            hold_v = dout_valid && !dout_ready;
            hold_d = dout;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int n;
        logic [7:0] bub[3];

        // Reset state
        #1;
        check("rst_valid", dout_valid, 0);
        check("rst_ready", din_ready, 0);
        check("rst_data", dout, 0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", din_ready, 0);
        step();
        check("ready_after_edge", din_ready, 1);

        // Basic
        dout_ready = 1'b1;
        din = 8'h83; din_valid = 1'b1;
        step();
        check("basic_valid0", dout_valid, 1);
        check("basic_data0", dout, 2'b11);
        din = 8'hC1;
        step();
        din_valid = 1'b0;
        check("basic_data1", dout, 2'b00);
        step();
        check("basic_idle", dout_valid, 0);

        // Streaming
        foreach (bub[i]) bub[i] = '0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: din = 8'h83;
                1: din = 8'hC1;
                2: din = 8'h03;
                default: din = 8'h80;
            endcase
            din_valid = 1'b1;
            check("stream_ready", din_ready, 1);
            step();
            check("stream_valid", dout_valid, 1);
        end
        din_valid = 1'b0;
        step();

        // Backpressure
        dout_ready = 1'b0;
        din = 8'h83; din_valid = 1'b1;
        step();
        din = 8'hC1;
        check("bp_ready_first", din_ready, 1);
        step();
        din_valid = 1'b0;
        check("bp_ready_drop", din_ready, 0);
        check("bp_hold_data", dout, 2'b11);
        repeat (3) step();
        check("bp_still_held", dout, 2'b11);
        dout_ready = 1'b1;
        step();
        check("bp_second", dout, 2'b00);
        check("bp_second_valid", dout_valid, 1);
        check("bp_ready_back", din_ready, 1);
        step();
        check("bp_drained", dout_valid, 0);

        // Reset mid-stream with both entries full
        dout_ready = 1'b0;
        din = 8'h03; din_valid = 1'b1;
        step();
        din = 8'h80;
        step();
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_ready", din_ready, 0);
        expq.delete();
        step();
        rst = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check("mid_rel_ready0", din_ready, 0);
        step();
        check("mid_rel_ready1", din_ready, 1);
        repeat (3) begin
            step();
            check("mid_no_stale", dout_valid, 0);
        end

        // Idle/bubble: valid pattern 1,0,1
        for (int i = 0; i < 3; i++) begin
            bub[i] = 8'($urandom);
            din = bub[i];
            din_valid = (i != 1);
            step();
            check("bubble_valid", dout_valid, (i != 1));
            if (i != 1)
                check("bubble_data", dout, model(bub[i]));
        end
        din_valid = 1'b0;
        step();

        // Exhaustive with random downstream ready
        for (int i = 0; i < 256; i++) begin
            din = 8'(i);
            din_valid = 1'b1;
            n = 0;
            do begin
                acc = din_ready;
                dout_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end while (!acc && n < 100);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept expected accept of %0h", i);
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("exh_drained", expq.size(), 0);
        repeat (2) step();
        check("exh_idle", dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
